// File: rtl/vco_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vco_ctrl_pkg
// Description : Shared definitions for the VCO-based ADC sequencing
//               controller: controller state encoding and the default
//               values of the top-level parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package vco_ctrl_pkg;

  localparam int c_phase_width   = 11;  // VCO phase word width
  localparam int c_osr_width     = 10;  // oversampling-count width
  localparam int c_settle_cycles = 4;   // VCO settle time in clk cycles

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_PRIME  = 2'd2,
    ST_ACCUM  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vco_adc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vco_adc_ctrl_if
// Description : Control, VCO and result-handshake signals of vco_adc_ctrl.
//               The 'master' modport is the controller side, the 'slave'
//               modport is the SoC / VCO environment side.
// Signals     : start, stop, cont, osr   - conversion control
//               p, vco_enb               - VCO phase word / active-low enable
//               busy                     - controller not idle
//               data, data_valid,
//               data_ready               - result valid/ready handshake
//               overrun                  - sticky result-overwrite flag
// Revision    : 1.0 - initial release
// ============================================================================
interface vco_adc_ctrl_if
  import vco_ctrl_pkg::*;
#(
  parameter int PHASE_WIDTH = c_phase_width,
  parameter int OSR_WIDTH   = c_osr_width
) ();

  localparam int ACC_WIDTH = PHASE_WIDTH + OSR_WIDTH;

  logic                   start;
  logic                   stop;
  logic                   cont;
  logic [OSR_WIDTH-1:0]   osr;
  logic [PHASE_WIDTH-1:0] p;
  logic                   vco_enb;
  logic                   busy;
  logic [ACC_WIDTH-1:0]   data;
  logic                   data_valid;
  logic                   data_ready;
  logic                   overrun;

  modport master (
    input  start, stop, cont, osr, p, data_ready,
    output vco_enb, busy, data, data_valid, overrun
  );

  modport slave (
    output start, stop, cont, osr, p, data_ready,
    input  vco_enb, busy, data, data_valid, overrun
  );

endinterface
`default_nettype wire

// File: rtl/vco_gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : vco_gray2bin
// Description : Combinational Gray-to-binary converter. Each binary bit is
//               the XOR of all Gray bits at or above its position.
// Ports       : gray - Gray-coded input word
//               bin  - equivalent binary word
// Revision    : 1.0 - initial release
// ============================================================================
module vco_gray2bin #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule
`default_nettype wire

// File: rtl/vco_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vco_adc_ctrl
// Description : Sequencing controller for a VCO-based ADC front end. Enables
//               the VCO (active-low), waits SETTLE_CYCLES, primes the phase
//               reference, then accumulates modulo-2^PHASE_WIDTH phase
//               differences over N = osr (0 treated as 1) cycles and presents
//               the sum on a valid/ready interface. Single-shot or
//               continuous operation; stop aborts from any state.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               bus  - vco_adc_ctrl_if.master (control, VCO, result)
// Options     : VCO_CTRL_GRAY_EN - when defined, p is Gray-coded and is
//               converted to binary ahead of the input register.
// Revision    : 1.0 - initial release
// ============================================================================
module vco_adc_ctrl
  import vco_ctrl_pkg::*;
#(
  parameter int PHASE_WIDTH   = c_phase_width,
  parameter int OSR_WIDTH     = c_osr_width,
  parameter int SETTLE_CYCLES = c_settle_cycles
) (
  input  logic           clk,
  input  logic           rst,
  vco_adc_ctrl_if.master bus
);

  localparam int ACC_WIDTH = PHASE_WIDTH + OSR_WIDTH;
  localparam int SW        = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] c_settle_last = SW'(SETTLE_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [PHASE_WIDTH-1:0] w_p_bin;
  logic [PHASE_WIDTH-1:0] r_p_q;
  logic [PHASE_WIDTH-1:0] r_prev;
  logic [PHASE_WIDTH-1:0] w_diff;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic [ACC_WIDTH-1:0]   r_data;
  logic [OSR_WIDTH-1:0]   r_n;
  logic [OSR_WIDTH-1:0]   r_cnt;
  logic [SW-1:0]          r_settle;
  logic                   r_cont;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   w_accept;
  logic                   w_settle_done;
  logic                   w_last;
  logic                   w_result;

  // --------------------------------------------------------------------------
  // Phase input decode (no added latency: conversion sits before r_p_q)
  // --------------------------------------------------------------------------
`ifdef VCO_CTRL_GRAY_EN
  vco_gray2bin #(
    .WIDTH (PHASE_WIDTH)
  ) u_gray2bin (
    .gray (bus.p),
    .bin  (w_p_bin)
  );
`else
  assign w_p_bin = bus.p;
`endif

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  assign w_accept      = (r_state == ST_IDLE) && bus.start && !bus.stop;
  assign w_settle_done = (r_settle == c_settle_last);
  assign w_last        = ((r_cnt + OSR_WIDTH'(1)) == r_n);
  // A completed window is discarded when stop arrives on the same cycle.
  assign w_result      = (r_state == ST_ACCUM) && w_last && !bus.stop;

  // Wrapping subtraction gives the unsigned phase advance across a wrap.
  assign w_diff = r_p_q - r_prev;
  assign w_sum  = r_acc + {{OSR_WIDTH{1'b0}}, w_diff};

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus.vco_enb = 1'b1;
    bus.busy    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (w_accept) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        bus.vco_enb = 1'b0;
        if (w_settle_done) w_next = ST_PRIME;
      end
      ST_PRIME: begin
        bus.vco_enb = 1'b0;
        w_next      = ST_ACCUM;
      end
      ST_ACCUM: begin
        bus.vco_enb = 1'b0;
        if (w_last && !r_cont) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (bus.stop) w_next = ST_IDLE;
  end

  // --------------------------------------------------------------------------
  // Datapath and result handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_q     <= '0;
      r_prev    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_n       <= OSR_WIDTH'(1);
      r_settle  <= '0;
      r_cont    <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_p_q <= w_p_bin;

      case (r_state)
        ST_IDLE: begin
          r_acc    <= '0;
          r_cnt    <= '0;
          r_settle <= '0;
          if (w_accept) begin
            r_n    <= (bus.osr == '0) ? OSR_WIDTH'(1) : bus.osr;
            r_cont <= bus.cont;
          end
        end
        ST_SETTLE: r_settle <= r_settle + SW'(1);
        ST_PRIME:  r_prev   <= r_p_q;
        ST_ACCUM: begin
          r_prev <= r_p_q;
          // Window complete: restart from zero; prev keeps chaining so the
          // next window in continuous mode loses no phase.
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + OSR_WIDTH'(1);
          end
        end
        default: ;
      endcase

      if (bus.stop) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_settle <= '0;
      end

      if (w_accept) r_overrun <= 1'b0;

      // A new result wins over a same-edge transfer; overrun only when the
      // held result was never taken.
      if (w_result) begin
        r_data  <= w_sum;
        r_valid <= 1'b1;
        if (r_valid && !bus.data_ready) r_overrun <= 1'b1;
      end else if (r_valid && bus.data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_valid;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vco_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vco_adc_ctrl
// Description : Self-checking bench for vco_adc_ctrl. A cycle-indexed
//               reference model predicts busy/enable, results and the
//               handshake flags from the conversion timing rules; directed
//               scenarios pin the model with literal expectations, followed
//               by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vco_adc_ctrl;
  import vco_ctrl_pkg::*;

  localparam int PW   = c_phase_width;
  localparam int OW   = c_osr_width;
  localparam int S    = c_settle_cycles;
  localparam int AW   = PW + OW;
  localparam int MASK = (1 << PW) - 1;
  localparam int MAXC = 16383;

  logic clk;
  logic rst;

  vco_adc_ctrl_if #(.PHASE_WIDTH(PW), .OSR_WIDTH(OW)) bus ();

  vco_adc_ctrl #(
    .PHASE_WIDTH   (PW),
    .OSR_WIDTH     (OW),
    .SETTLE_CYCLES (S)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pq [0:MAXC];         // p_q value (binary) during each cycle
  logic [PW-1:0] p_bin;
  int  step;
  bit  rand_p;
  bit  chk_en;
  int  low_cnt;
  int  first_valid;

  // Reference model state
  bit            m_active;
  bit            m_cont;
  bit            m_valid;
  bit            m_ovr;
  int            m_c0;
  int            m_n;
  logic [AW-1:0] m_data;

  function automatic logic [PW-1:0] enc(logic [PW-1:0] b);
`ifdef VCO_CTRL_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_cont   = 1'b0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_c0     = 0;
    m_n      = 1;
    m_data   = '0;
  endtask

  // Applies the inputs present at the edge that ends cycle 'cyc'.
  task automatic model_step();
    bit            res;
    int            rel;
    logic [AW-1:0] sum;
    res = 1'b0;
    sum = '0;
    if (bus.stop) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1'b1;
        m_c0     = cyc;
        m_n      = (bus.osr == '0) ? 1 : int'(bus.osr);
        m_cont   = bus.cont;
        m_ovr    = 1'b0;
      end
    end else begin
      // Accumulation cycles are c0+S+2 onward; a window of N ends every N.
      rel = cyc - m_c0;
      if (rel >= S + 2 && ((rel - S - 1) % m_n) == 0) begin
        res = 1'b1;
        for (int i = cyc - m_n + 1; i <= cyc; i++)
          sum = sum + AW'((pq[i] - pq[i-1]) & MASK);
        if (!m_cont) m_active = 1'b0;
      end
    end
    if (res) begin
      if (m_valid && !bus.data_ready) m_ovr = 1'b1;
      m_data  = sum;
      m_valid = 1'b1;
    end else if (m_valid && bus.data_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      model_reset();
      pq[cyc+1] = 0;
    end else begin
      model_step();
      pq[cyc+1] = int'(p_bin);
    end
    cyc++;
    #1;
    if (rand_p) p_bin = PW'($urandom);
    else        p_bin = p_bin + PW'(step);
    bus.p = enc(p_bin);
  endtask

  task automatic set_p(int v);
    p_bin = PW'(v);
    bus.p = enc(p_bin);
  endtask

  task automatic launch(int osr_v, bit cont_v);
    bus.osr   = OW'(osr_v);
    bus.cont  = cont_v;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.cont  = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("vco_enb",    64'(bus.vco_enb),    64'(!m_active));
      chk("busy",       64'(bus.busy),       64'(m_active));
      chk("data_valid", 64'(bus.data_valid), 64'(m_valid));
      chk("overrun",    64'(bus.overrun),    64'(m_ovr));
      chk("data",       64'(bus.data),       64'(m_data));
    end
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.cont       = 1'b0;
    bus.osr        = '0;
    bus.data_ready = 1'b0;
    p_bin          = '0;
    bus.p          = '0;
    step           = 7;
    rand_p         = 1'b0;
    chk_en         = 1'b0;
    model_reset();
    for (int i = 0; i <= MAXC; i++) pq[i] = 0;

    cycle();
    cycle();
    chk("rst_vco_enb", 64'(bus.vco_enb),    64'd1);
    chk("rst_busy",    64'(bus.busy),       64'd0);
    chk("rst_data",    64'(bus.data),       64'd0);
    chk("rst_valid",   64'(bus.data_valid), 64'd0);
    chk("rst_overrun", 64'(bus.overrun),    64'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    cycle();

    // Single-shot ramp, +7 per cycle, osr=4
    step = 7;
    launch(4, 1'b0);
    low_cnt     = 0;
    first_valid = -1;
    for (int k = 1; k <= S + 8; k++) begin
      if (!bus.vco_enb) low_cnt++;
      if (bus.data_valid && first_valid < 0) first_valid = k;
      cycle();
    end
    chk("ramp_enb_low",    64'(low_cnt),     64'(S + 5));
    chk("ramp_first_vld",  64'(first_valid), 64'(S + 6));
    chk("ramp_data",       64'(bus.data),    64'd28);
    bus.data_ready = 1'b1;
    cycle();
    bus.data_ready = 1'b0;

    // Phase wrap: p_q = 2040, 2047, 5, 12 with osr=3
    launch(3, 1'b0);
    for (int k = 1; k <= S + 3; k++) begin
      if (k == S)     set_p(2040);
      if (k == S + 1) set_p(2047);
      if (k == S + 2) set_p(5);
      if (k == S + 3) set_p(12);
      cycle();
    end
    cycle();
    chk("wrap_data",  64'(bus.data),       64'd20);
    chk("wrap_valid", 64'(bus.data_valid), 64'd1);
    bus.data_ready = 1'b1;
    cycle();
    bus.data_ready = 1'b0;

    // Continuous, osr=2, +3 per cycle, consumer stalled
    step = 3;
    launch(2, 1'b1);
    repeat (S + 4) cycle();
    chk("bp_data1",  64'(bus.data),       64'd6);
    chk("bp_valid1", 64'(bus.data_valid), 64'd1);
    chk("bp_ovr1",   64'(bus.overrun),    64'd0);
    repeat (2) cycle();
    chk("bp_ovr2",   64'(bus.overrun),    64'd1);
    chk("bp_data2",  64'(bus.data),       64'd6);
    cycle();
    bus.data_ready = 1'b1;
    cycle();
    bus.data_ready = 1'b0;
    chk("bp_vld_clr",  64'(bus.data_valid), 64'd0);
    chk("bp_ovr_kept", 64'(bus.overrun),    64'd1);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    chk("bp_stop_busy", 64'(bus.busy),    64'd0);
    chk("bp_ovr_stop",  64'(bus.overrun), 64'd1);
    cycle();

    // Abort in 2nd ACCUM cycle with a simultaneous start
    step = 5;
    launch(4, 1'b0);
    chk("abort_ovr_clr", 64'(bus.overrun), 64'd0);
    repeat (S + 2) cycle();
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    cycle();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk("abort_enb",  64'(bus.vco_enb),    64'd1);
    chk("abort_busy", 64'(bus.busy),       64'd0);
    chk("abort_vld",  64'(bus.data_valid), 64'd0);
    repeat (6) cycle();
    chk("abort_no_vld", 64'(bus.data_valid), 64'd0);

    // osr=1 after abort: single difference
    launch(1, 1'b0);
    repeat (S + 2) cycle();
    chk("osr1_data",  64'(bus.data),       64'd5);
    chk("osr1_valid", 64'(bus.data_valid), 64'd1);
    bus.data_ready = 1'b1;
    cycle();
    bus.data_ready = 1'b0;

    // osr=0 behaves as osr=1
    step = 9;
    launch(0, 1'b0);
    repeat (S + 2) cycle();
    chk("osr0_data",  64'(bus.data),       64'd9);
    chk("osr0_valid", 64'(bus.data_valid), 64'd1);
    chk("osr0_idle",  64'(bus.busy),       64'd0);

    // Asynchronous reset in the middle of ACCUM, with a result still held
    step = 2;
    launch(8, 1'b0);
    repeat (S + 3) cycle();
    chk("arst_pre_busy", 64'(bus.busy), 64'd1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_vco_enb", 64'(bus.vco_enb),    64'd1);
    chk("arst_busy",    64'(bus.busy),       64'd0);
    chk("arst_data",    64'(bus.data),       64'd0);
    chk("arst_valid",   64'(bus.data_valid), 64'd0);
    chk("arst_overrun", 64'(bus.overrun),    64'd0);
    cycle();
    rst = 1'b0;
    cycle();

`ifdef VCO_CTRL_GRAY_EN
    // Gray input 0,1,3,2 (binary 0,1,2,3), osr=3
    launch(3, 1'b0);
    for (int k = 1; k <= S + 3; k++) begin
      if (k >= S) set_p(k - S);
      cycle();
    end
    cycle();
    chk("gray_data", 64'(bus.data), 64'd3);
    bus.data_ready = 1'b1;
    cycle();
    bus.data_ready = 1'b0;
`endif

    // Randomized traffic
    rand_p = 1'b1;
    repeat (3000) begin
      bus.start      = ($urandom % 8) == 0;
      bus.stop       = ($urandom % 40) == 0;
      bus.cont       = ($urandom % 3) == 0;
      bus.osr        = OW'($urandom % 7);
      bus.data_ready = ($urandom % 2) == 1;
      cycle();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    cycle();
    bus.stop = 1'b0;
    cycle();
    chk("final_idle", 64'(bus.busy), 64'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vco_adc_ctrl.md
# vco_adc_ctrl

Sequencing controller for the `vco_r100` phase-output VCO used as a VCO-based ADC front end. It drives the VCO's active-low enable and waits a programmable settle time. It then differentiates the sampled phase word modulo 2^PHASE_WIDTH and accumulates the differences over a programmable oversampling window. The decimated result is delivered on a valid/ready interface to the SoC-side readout logic.

## Interface
- `PHASE_WIDTH`, 11, width of VCO phase word `p`
- `OSR_WIDTH`, 10, width of oversampling-count input
- `SETTLE_CYCLES`, 4, cycles between enabling the VCO and the first phase capture (must be ≥1)
- `ACC_WIDTH`, PHASE_WIDTH+OSR_WIDTH, accumulator/result width (derived, not overridden)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  conversion request pulse, honoured only in IDLE
- `stop`  in  1  abort; forces IDLE from any state
- `cont`  in  1  continuous mode, latched on accepted `start`
- `osr`  in  OSR_WIDTH  number of phase differences per result, latched on accepted `start`; 0 is treated as 1
- `p`  in  PHASE_WIDTH  VCO phase word
- `vco_enb`  out  1  VCO enable, active-low, to `vco_r100.enb`
- `busy`  out  1  high in any state except IDLE
- `data`  out  ACC_WIDTH  decimated result
- `data_valid`  out  1  result available
- `data_ready`  in  1  consumer accepts result
- `overrun`  out  1  sticky: a result was overwritten before acceptance

## Operation
- Input stage: `p` is registered every cycle into `p_q`. `p_q` is the only phase source; all phase references below mean `p_q`.
- States and transitions:
  - IDLE: `vco_enb`=1, accumulator and counters cleared.
    - `start` && !`stop` → SETTLE. Latches `osr` (0→1) and `cont`, and clears `overrun`.
  - SETTLE: `vco_enb`=0, settle counter runs for SETTLE_CYCLES cycles → PRIME.
  - PRIME: one cycle. `prev` ← `p_q` → ACCUM.
  - ACCUM:
    - Each cycle: `diff` = (`p_q` − `prev`) mod 2^PHASE_WIDTH, unsigned; `acc` += `diff`; `prev` ← `p_q`; `cnt`++.
    - On the cycle when `cnt` reaches N, the final sum (`acc`+`diff`) is loaded into the `data` register and `data_valid` is set.
    - Then, if `cont`: `acc` and `cnt` are cleared and ACCUM continues with no gap; `prev` chaining is preserved.
    - Otherwise → IDLE.
- `stop` has priority over all transitions, including a simultaneous `start`. It forces IDLE next cycle and discards the partial `acc`. An already-valid `data` is kept.
- `start` outside IDLE is ignored.
- Arithmetic: `diff` is zero-extended to ACC_WIDTH. `acc` cannot overflow, since N ≤ 2^OSR_WIDTH−1 and `diff` ≤ 2^PHASE_WIDTH−1.
- Output handshake:
  - `data_valid` holds and `data` stays stable until a cycle with `data_valid && data_ready`; `data_valid` clears on that edge.
  - A new result on the same edge as the transfer loads the new value and keeps `data_valid`=1, with no overrun.
  - A new result while `data_valid && !data_ready`: `data` is overwritten and `overrun` is set.

## Timing
- Reset values: `vco_enb`=1, `busy`=0, `data`=0, `data_valid`=0, `overrun`=0, state IDLE.
- Cycle 0 samples `start`. Cycles 1..S are SETTLE, with `vco_enb`=0 from cycle 1. Cycle S+1 is PRIME. Cycles S+2..S+1+N are ACCUM.
- `data_valid` is high from cycle S+2+N.
- In single-shot mode, `vco_enb` returns to 1 and `busy` to 0 in cycle S+2+N.
- In continuous mode, results arrive every N cycles.
- `stop` sampled in cycle k gives `vco_enb`=1 and `busy`=0 in cycle k+1.
- `rst` asserted mid-conversion returns every output to its reset value immediately, without waiting for a clock edge.

## Configuration
- `VCO_CTRL_GRAY_EN` defined: `p` is Gray-coded. The input stage registers Gray-to-binary(`p`), adding no extra cycle; the conversion is combinational before the `p_q` register.
- `VCO_CTRL_GRAY_EN` undefined: `p` is plain binary and is registered unchanged.

## Structure
- Shared package `vco_ctrl_pkg`: state enum (IDLE, SETTLE, PRIME, ACCUM), and the default constants for PHASE_WIDTH, OSR_WIDTH and SETTLE_CYCLES.
- One sub-module, `vco_gray2bin` (parameterised by width, combinational). It is instantiated only under `VCO_CTRL_GRAY_EN`.

## Test plan
- Single-shot ramp: `p` increments by 7 per cycle, `osr`=4, `cont`=0 → one result `data`=28 at cycle S+6; `vco_enb`=0 for exactly S+5 cycles, then 1.
- Phase wrap: the `p_q` sequence 2040, 2047, 5, 12, `osr`=3 → `data`=7+6+7=20; no negative difference.
- Continuous with back-pressure: `osr`=2, increment 3, `data_ready`=0 → `data` is 6 and `overrun` goes 1 on the second result. Raising `data_ready` for one cycle clears `data_valid` only; `overrun` stays 1 until the next `start`.
- Abort: `stop` asserted in the 2nd ACCUM cycle together with `start` → IDLE next cycle, `vco_enb`=1, no new `data_valid`; a following `start` with `osr`=1 gives a single-difference result.
- `osr`=0 → behaves as `osr`=1; the result equals a single difference.
- Async reset mid-ACCUM → all outputs reach their reset values before the next clock edge; with `VCO_CTRL_GRAY_EN`, Gray input 0,1,3,2 (binary 0,1,2,3), `osr`=3 → `data`=3.
